// File: rtl/mux_pkg.sv
// Shared constants and select-index type for the 4:1 lane multiplexer.
package mux_pkg;

    localparam int MUX_N_IN  = 4;
    localparam int MUX_SEL_W = 2;

    typedef logic [MUX_SEL_W-1:0] mux_sel_t;

endpackage

// File: rtl/mux_lane_sel.sv
// Pure combinational 4:1 lane selector; lane k lives at data[k*WIDTH +: WIDTH].
module mux_lane_sel
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [MUX_N_IN*WIDTH-1:0] data,
    input  mux_sel_t                  sel,
    output logic [WIDTH-1:0]          y
);

    logic [WIDTH-1:0] lanes [MUX_N_IN];

    for (genvar k = 0; k < MUX_N_IN; k++) begin : g_lane
        assign lanes[k] = data[k*WIDTH +: WIDTH];
    end

    // An X/Z select propagates X to y; no squashing on purpose.
    assign y = lanes[sel];

endmodule

// File: rtl/mux.sv
// 4:1 multiplexer with a combinational output Y and a registered copy Y_q.
module mux
    import mux_pkg::*;
#(
    parameter int          WIDTH   = 1,
    parameter int unsigned RST_VAL = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MUX_N_IN*WIDTH-1:0] I,
    input  logic                      S1,
    input  logic                      S2,
    output logic [WIDTH-1:0]          Y,
    output logic [WIDTH-1:0]          Y_q
);

    // RST_VAL is truncated or zero-extended to the lane width.
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    mux_sel_t sel;

    assign sel = {S2, S1};

    mux_lane_sel #(
        .WIDTH (WIDTH)
    ) u_lane_sel (
        .data (I),
        .sel  (sel),
        .y    (Y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q <= RST_Q;
        end else begin
            Y_q <= Y;
        end
    end

endmodule

// File: tb/tb_mux.sv
// Self-checking bench for mux: directed cases plus randomized stimulus against a lane-shift model.
module tb_mux;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;

    logic        rst1 = 1'b0;
    logic [3:0]  i1 = '0;
    logic        s1a = 1'b0, s2a = 1'b0;
    logic        y1, yq1;

    logic        rst8 = 1'b0;
    logic [31:0] i8 = '0;
    logic        s1b = 1'b0, s2b = 1'b0;
    logic [7:0]  y8, yq8;

    int n_cmp = 0;
    int n_err = 0;

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    mux u_dut1 (
        .clk (clk), .rst (rst1), .I (i1), .S1 (s1a), .S2 (s2a), .Y (y1), .Y_q (yq1)
    );

    mux #(.WIDTH(8), .RST_VAL(32'hA5)) u_dut8 (
        .clk (clk), .rst (rst8), .I (i8), .S1 (s1b), .S2 (s2b), .Y (y8), .Y_q (yq8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: lane sel is the sel-th group of w bits counting from the LSB.
    function automatic logic [31:0] ref_y(input logic [31:0] data, input int sel, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (data >> (sel * w)) & mask;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input logic [3:0] data, input int sel);
        i1  = data;
        s2a = sel[1];
        s1a = sel[0];
    endtask

    task automatic set8(input logic [31:0] data, input int sel);
        i8  = data;
        s2b = sel[1];
        s1b = sel[0];
    endtask

    initial begin
        logic [3:0]  sw_i [5];
        int          sw_s [5];
        logic [31:0] exp_q1, exp_q8;
        int          r_sel1, r_sel8;

        // Combinational sweep with the clock stopped.
        sw_i[0] = 4'b0010; sw_s[0] = 0;
        sw_i[1] = 4'b0110; sw_s[1] = 1;
        sw_i[2] = 4'b1110; sw_s[2] = 2;
        sw_i[3] = 4'b1010; sw_s[3] = 3;
        sw_i[4] = 4'b0110; sw_s[4] = 2;
        for (int k = 0; k < 5; k++) begin
            set1(sw_i[k], sw_s[k]);
            #80;
            chk($sformatf("sweep%0d", k), {31'd0, y1}, ref_y({28'd0, sw_i[k]}, sw_s[k], 1));
        end
        chk("sweep0_const", {31'd0, y1}, 32'd1);

        for (int v = 0; v < 16; v++) begin
            for (int s = 0; s < 4; s++) begin
                set1(v[3:0], s);
                #1;
                chk($sformatf("exh_i%0d_s%0d", v, s), {31'd0, y1}, ref_y(v, s, 1));
            end
        end

        clk_run = 1'b1;
        #1;

        // Reset with sel=3, I=1000.
        set1(4'b1000, 3);
        rst1 = 1'b1;
        rst8 = 1'b1;
        step();
        chk("rst_e1_yq", {31'd0, yq1}, 32'd0);
        chk("rst_e1_y", {31'd0, y1}, 32'd1);
        chk("rst8_yq", {24'd0, yq8}, 32'hA5);
        step();
        chk("rst_e2_yq", {31'd0, yq1}, 32'd0);
        chk("rst_e2_y", {31'd0, y1}, 32'd1);
        rst1 = 1'b0;
        rst8 = 1'b0;
        #1;
        chk("rel_y", {31'd0, y1}, 32'd1);
        chk("rel_yq_hold", {31'd0, yq1}, 32'd0);
        step();
        chk("rel_yq", {31'd0, yq1}, 32'd1);

        // Pipeline latency on the 8-bit instance.
        for (int s = 0; s < 4; s++) begin
            set8(32'h44332211, s);
            #1;
            chk($sformatf("pipe_y%0d", s), {24'd0, y8}, 32'h11 * (s + 1));
            step();
            chk($sformatf("pipe_yq%0d", s), {24'd0, yq8}, 32'h11 * (s + 1));
        end

        // Mid-operation reset while Y=33.
        set8(32'h44332211, 2);
        rst8 = 1'b1;
        step();
        chk("mid_rst_yq", {24'd0, yq8}, 32'hA5);
        chk("mid_rst_y", {24'd0, y8}, 32'h33);
        rst8 = 1'b0;
        step();
        chk("mid_resume_yq", {24'd0, yq8}, 32'h33);

        // Reset pulse between edges must be ignored.
        set8(32'h44332211, 3);
        step();
        chk("pulse_pre", {24'd0, yq8}, 32'h44);
        set8(32'h44332211, 0);
        #1;
        rst8 = 1'b1;
        #2;
        rst8 = 1'b0;
        #1;
        chk("pulse_between", {24'd0, yq8}, 32'h44);
        step();
        chk("pulse_after", {24'd0, yq8}, 32'h11);

        // Randomized: both instances, occasional reset, inputs and select changing together.
        for (int n = 0; n < 300; n++) begin
            r_sel1 = int'($urandom_range(0, 3));
            r_sel8 = int'($urandom_range(0, 3));
            set1(4'($urandom), r_sel1);
            set8($urandom, r_sel8);
            rst1 = ($urandom_range(0, 7) == 0);
            rst8 = ($urandom_range(0, 7) == 0);
            #1;
            chk("rnd_y1", {31'd0, y1}, ref_y({28'd0, i1}, r_sel1, 1));
            chk("rnd_y8", {24'd0, y8}, ref_y(i8, r_sel8, 8));
            exp_q1 = rst1 ? 32'd0 : ref_y({28'd0, i1}, r_sel1, 1);
            exp_q8 = rst8 ? 32'hA5 : ref_y(i8, r_sel8, 8);
            step();
            chk("rnd_yq1", {31'd0, yq1}, exp_q1);
            chk("rnd_yq8", {24'd0, yq8}, exp_q8);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
